// File: rtl/fsm_calibration_multi_pkg.sv
// rtl/fsm_calibration_multi_pkg.sv - shared types and defaults for the calibration sequencer
`timescale 1ns/1ps
package fsm_calibration_multi_pkg;

  localparam int CALIB_CNT_W  = 32;
  localparam int CALIB_SHOT_W = 8;

  typedef struct packed {
    logic [CALIB_CNT_W-1:0]  fg_open_delay;
    logic [CALIB_CNT_W-1:0]  ready_timeout;
    logic [CALIB_CNT_W-1:0]  detonate_len;
    logic [CALIB_CNT_W-1:0]  trigger_len;
    logic [CALIB_CNT_W-1:0]  shot_gap;
    logic [CALIB_SHOT_W-1:0] n_shots;
  } calib_par_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FG,
    S_FG_DELAY,
    S_WAIT_READY,
    S_FIRE,
    S_GAP,
    S_DONE,
    S_TIMEOUT
  } calib_state_t;

  // A burst always contains at least one shot.
  function automatic logic [CALIB_SHOT_W-1:0] calib_shots_target(input logic [CALIB_SHOT_W-1:0] n);
    return (n == '0) ? CALIB_SHOT_W'(1) : n;
  endfunction

endpackage

// File: rtl/calib_pulse_gen.sv
// rtl/calib_pulse_gen.sv - one-shot pulse: waits `delay` cycles after load, then high for max(len,1) cycles
// last is high when the generator is idle or in its final high cycle.
`timescale 1ns/1ps
module calib_pulse_gen
  import fsm_calibration_multi_pkg::*;
#(
  parameter int CNT_W = CALIB_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] len,
  output logic             pulse,
  output logic             last
);

  logic             active_q, active_d;
  logic [CNT_W-1:0] dly_q, dly_d;
  logic [CNT_W-1:0] len_q, len_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      dly_q    <= '0;
      len_q    <= '0;
    end else begin
      active_q <= active_d;
      dly_q    <= dly_d;
      len_q    <= len_d;
    end
  end

  always_comb begin
    active_d = active_q;
    dly_d    = dly_q;
    len_d    = len_q;
    if (clear) begin
      active_d = 1'b0;
      dly_d    = '0;
      len_d    = '0;
    end else if (load) begin
      active_d = 1'b1;
      dly_d    = delay;
      len_d    = (len == '0) ? CNT_W'(1) : len;
    end else if (active_q) begin
      if (dly_q != '0) begin
        dly_d = dly_q - CNT_W'(1);
      end else if (len_q > CNT_W'(1)) begin
        len_d = len_q - CNT_W'(1);
      end else begin
        active_d = 1'b0;
        len_d    = '0;
      end
    end
  end

  assign pulse = active_q && (dly_q == '0);
  assign last  = !active_q || ((dly_q == '0) && (len_q <= CNT_W'(1)));

endmodule

// File: rtl/fsm_calibration_multi.sv
// rtl/fsm_calibration_multi.sv - calibration sequencer: fast-gate wait, ready gating, phased multi-channel fire bursts
// Optional abort input enabled by CALIB_ABORT_EN.
`timescale 1ns/1ps
module fsm_calibration_multi
  import fsm_calibration_multi_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int CNT_W  = CALIB_CNT_W,
  parameter int SHOT_W = CALIB_SHOT_W
) (
  input  logic                       clock,
  input  logic                       reset,
`ifdef CALIB_ABORT_EN
  input  logic                       abort,
`endif
  input  calib_par_t                 par,
  input  logic [N_CH-1:0]            ch_en,
  input  logic [N_CH-1:0][CNT_W-1:0] phase_shift,
  input  logic                       start,
  input  logic                       fg_opto,
  input  logic [N_CH-1:0]            detector_ready,
  output logic                       detonate,
  output logic [N_CH-1:0]            output_trigger,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout_err
);

  calib_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]  gap_q, gap_d;
  logic [SHOT_W-1:0] shot_q, shot_d, shot_inc;
  logic [SHOT_W-1:0] nshot_q, nshot_d;
  logic              err_q, err_d;
  logic              start_q;
  logic              abort_i;
  logic              fire_load;
  logic              ready_ok;
  logic              fire_last;
  logic              det_pulse, det_last;
  logic [N_CH-1:0]   trg_pulse, trg_last;

`ifdef CALIB_ABORT_EN
  assign abort_i = abort && (state_q != S_IDLE);
`else
  assign abort_i = 1'b0;
`endif

  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign shot_inc  = (&shot_q) ? shot_q : shot_q + SHOT_W'(1);
  assign ready_ok  = ((detector_ready & ch_en) == ch_en);
  assign fire_last = det_last && (&trg_last);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      shot_q  <= '0;
      nshot_q <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      shot_q  <= shot_d;
      nshot_q <= nshot_d;
      err_q   <= err_d;
      start_q <= start;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    shot_d    = shot_q;
    nshot_d   = nshot_q;
    err_d     = err_q;
    fire_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !start_q) begin
          state_d = S_WAIT_FG;
          shot_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_WAIT_FG: begin
        if (fg_opto) begin
          state_d = S_FG_DELAY;
          cnt_d   = '0;
        end
      end
      // Losing the fast gate restarts the whole open delay.
      S_FG_DELAY: begin
        if (!fg_opto) begin
          state_d = S_WAIT_FG;
          cnt_d   = '0;
        end else if (cnt_inc >= CNT_W'(par.fg_open_delay)) begin
          state_d = S_WAIT_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT_READY: begin
        if (ready_ok) begin
          state_d   = S_FIRE;
          fire_load = 1'b1;
          cnt_d     = '0;
          gap_d     = CNT_W'(par.shot_gap);
          nshot_d   = SHOT_W'(calib_shots_target(par.n_shots));
        end else if ((par.ready_timeout != '0) && (cnt_inc >= CNT_W'(par.ready_timeout))) begin
          state_d = S_TIMEOUT;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_FIRE: begin
        if (fire_last) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (cnt_inc >= gap_q) begin
          cnt_d   = '0;
          shot_d  = shot_inc;
          state_d = (shot_inc < nshot_q) ? S_WAIT_FG : S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE:    state_d = S_IDLE;
      S_TIMEOUT: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (abort_i) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      fire_load = 1'b0;
      err_d     = err_q;
    end
  end

  calib_pulse_gen #(.CNT_W(CNT_W)) u_det (
    .clock (clock),
    .reset (reset),
    .load  (fire_load),
    .clear (abort_i),
    .delay ('0),
    .len   (CNT_W'(par.detonate_len)),
    .pulse (det_pulse),
    .last  (det_last)
  );

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    calib_pulse_gen #(.CNT_W(CNT_W)) u_trg (
      .clock (clock),
      .reset (reset),
      .load  (fire_load && ch_en[i]),
      .clear (abort_i),
      .delay (phase_shift[i]),
      .len   (CNT_W'(par.trigger_len)),
      .pulse (trg_pulse[i]),
      .last  (trg_last[i])
    );
  end

  assign detonate       = det_pulse && !abort_i;
  assign output_trigger = trg_pulse & {N_CH{!abort_i}};
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign timeout_err    = err_q;

endmodule

// File: tb/tb_fsm_calibration_multi.sv
// tb/tb_fsm_calibration_multi.sv - self-checking bench for fsm_calibration_multi
// Optional abort checks built when CALIB_ABORT_EN is defined.
`timescale 1ns/1ps
module tb_fsm_calibration_multi;
  import fsm_calibration_multi_pkg::*;

  localparam int N_CH  = 4;
  localparam int CNT_W = 32;
  localparam int MAXC  = 400;

  logic                       clock = 1'b0;
  logic                       reset = 1'b1;
  calib_par_t                 par;
  logic [N_CH-1:0]            ch_en;
  logic [N_CH-1:0][CNT_W-1:0] phase_shift;
  logic                       start;
  logic                       fg_opto;
  logic [N_CH-1:0]            detector_ready;
  logic                       detonate;
  logic [N_CH-1:0]            output_trigger;
  logic                       busy;
  logic                       done;
  logic                       timeout_err;
`ifdef CALIB_ABORT_EN
  logic                       abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  fsm_calibration_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .SHOT_W(CALIB_SHOT_W)) dut (
    .clock          (clock),
    .reset          (reset),
`ifdef CALIB_ABORT_EN
    .abort          (abort),
`endif
    .par            (par),
    .ch_en          (ch_en),
    .phase_shift    (phase_shift),
    .start          (start),
    .fg_opto        (fg_opto),
    .detector_ready (detector_ready),
    .detonate       (detonate),
    .output_trigger (output_trigger),
    .busy           (busy),
    .done           (done),
    .timeout_err    (timeout_err)
  );

  always #2.5 clock = ~clock;

  typedef struct {
    int         d, to, dl, tl, gap, n;
    logic [3:0] en, rdy;
    int         ph[4];
    int         exp_fire, exp_end;
  } vec_t;

  logic       m_det[MAXC];
  logic [3:0] m_trg[MAXC];
  logic       m_done[MAXC];
  logic       m_busy[MAXC];
  logic       m_err[MAXC];
  int         nb[5];
  int         fb[5];

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void acc(input int k, input logic ok, input int c);
    if (!ok) begin
      nb[k]++;
      if (fb[k] < 0) fb[k] = c;
    end
  endfunction

  function automatic int m1(input int v);
    return (v <= 0) ? 1 : v;
  endfunction

  function automatic vec_t mk(input int d, to, dl, tl, gap, n, input logic [3:0] en, rdy,
                              input int p0, p1, p2, p3, ef, ee);
    vec_t v;
    v.d = d; v.to = to; v.dl = dl; v.tl = tl; v.gap = gap; v.n = n;
    v.en = en; v.rdy = rdy;
    v.ph[0] = p0; v.ph[1] = p1; v.ph[2] = p2; v.ph[3] = p3;
    v.exp_fire = ef; v.exp_end = ee;
    return v;
  endfunction

  // Cycle 0 is the cycle start is raised; cycle 1 is the first busy cycle.
  task automatic model(input vec_t v, output int endc);
    int f, e, c2, te;
    for (int c = 0; c < MAXC; c++) begin
      m_det[c] = 1'b0; m_trg[c] = '0; m_done[c] = 1'b0; m_busy[c] = 1'b0; m_err[c] = 1'b0;
    end
    c2 = 0;
    if ((v.rdy & v.en) != v.en) begin
      endc = 2 + m1(v.d) + v.to;
      for (int c = endc; c < MAXC; c++) m_err[c] = 1'b1;
    end else begin
      f = 3 + m1(v.d);
      for (int s = 0; s < m1(v.n); s++) begin
        e = f + m1(v.dl) - 1;
        for (int c = f; c <= e; c++) m_det[c] = 1'b1;
        for (int i = 0; i < 4; i++) begin
          if (v.en[i]) begin
            te = f + v.ph[i] + m1(v.tl) - 1;
            for (int c = f + v.ph[i]; c <= te; c++) m_trg[c][i] = 1'b1;
            if (te > e) e = te;
          end
        end
        c2 = e + 1 + m1(v.gap);
        f  = c2 + 2 + m1(v.d);
      end
      endc = c2;
      m_done[endc] = 1'b1;
    end
    for (int c = 1; c <= endc; c++) m_busy[c] = 1'b1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_par(input vec_t v);
    par.fg_open_delay = CALIB_CNT_W'(v.d);
    par.ready_timeout = CALIB_CNT_W'(v.to);
    par.detonate_len  = CALIB_CNT_W'(v.dl);
    par.trigger_len   = CALIB_CNT_W'(v.tl);
    par.shot_gap      = CALIB_CNT_W'(v.gap);
    par.n_shots       = CALIB_SHOT_W'(v.n);
    ch_en             = v.en;
    detector_ready    = v.rdy;
    for (int i = 0; i < N_CH; i++) phase_shift[i] = CNT_W'(v.ph[i]);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int    endc, len, a_fire, a_end;
    string sn[5];
    sn[0] = "det"; sn[1] = "trg"; sn[2] = "done"; sn[3] = "busy"; sn[4] = "err";
    model(v, endc);
    len = endc + 3;
    for (int k = 0; k < 5; k++) begin nb[k] = 0; fb[k] = -1; end
    a_fire = -1;
    a_end  = -1;
    tick();
    apply_par(v);
    fg_opto = 1'b1;
    start   = 1'b1;
    for (int c = 1; c <= len; c++) begin
      tick();
      // A second start edge while busy must be ignored.
      if (c == 2 || c == 4) start = 1'b0;
      else if (c == 3) start = 1'b1;
      #1;
      if (detonate && a_fire < 0) a_fire = c;
      if (busy) a_end = c;
      acc(0, detonate === m_det[c], c);
      acc(1, output_trigger === m_trg[c], c);
      acc(2, done === m_done[c], c);
      acc(3, busy === m_busy[c], c);
      acc(4, timeout_err === m_err[c], c);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (nb[k] != 0) begin
        errors++;
        $display("FAIL %s_%s: %0d cycles differ from model (first at cycle %0d), expected 0",
                 name, sn[k], nb[k], fb[k]);
      end
    end
    if (v.exp_end >= 0) begin
      check({name, "_fire_cycle"}, a_fire, v.exp_fire);
      check({name, "_end_cycle"}, a_end, v.exp_end);
    end
    fg_opto = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[7];
    vec_t       v;
    logic [3:0] tmp;
    int         first, n_det, n_trg, n_done;

    par = '0; ch_en = '0; phase_shift = '0; start = 1'b0; fg_opto = 1'b0; detector_ready = '0;

    tbl[0] = mk(10, 0, 20, 20, 5, 1, 4'b1111, 4'b1111, 0, 3, 7, 140, 13, 178);
    tbl[1] = mk(10, 50, 20, 20, 5, 1, 4'b1111, 4'b1011, 0, 3, 7, 140, -1, 62);
    tbl[2] = mk(10, 0, 20, 20, 5, 3, 4'b1111, 4'b1111, 0, 0, 0, 0, 13, 112);
    tbl[3] = mk(10, 0, 20, 20, 5, 1, 4'b0101, 4'b0101, 0, 3, 7, 140, 13, 45);
    tbl[4] = mk(10, 0, 20, 20, 5, 1, 4'b0000, 4'b0000, 0, 3, 7, 140, 13, 38);
    tbl[5] = mk(0, 0, 0, 0, 0, 0, 4'b1111, 4'b1111, 0, 0, 0, 0, 4, 6);
    tbl[6] = mk(0, 1, 0, 0, 0, 0, 4'b0001, 4'b0001, 0, 0, 0, 0, 4, 6);

    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", int'({detonate, output_trigger, busy, done, timeout_err}), 0);
    reset = 1'b0;
    tick();
    tick();
    check("idle_after_reset", int'(busy), 0);

    for (int t = 0; t < 7; t++) run_vec(tbl[t], $sformatf("tbl%0d", t));

    for (int r = 0; r < 20; r++) begin
      v = mk($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 6),
             $urandom_range(0, 4), $urandom_range(0, 3), 4'($urandom_range(0, 15)), 4'b0000,
             $urandom_range(0, 10), $urandom_range(0, 10), $urandom_range(0, 10), $urandom_range(0, 10),
             -1, -1);
      if (v.en != 4'b0000 && $urandom_range(0, 3) == 0) begin
        tmp   = v.en - 4'd1;
        v.rdy = (v.en & tmp) | (~v.en & 4'($urandom_range(0, 15)));
        v.to  = $urandom_range(1, 20);
      end else begin
        v.rdy = v.en | 4'($urandom_range(0, 15));
      end
      run_vec(v, $sformatf("rnd%0d", r));
    end

    // Fast gate drops on the 6th delay cycle, then re-opens; params change mid-shot.
    v = mk(10, 0, 3, 3, 1, 1, 4'b0001, 4'b1111, 0, 0, 0, 0, -1, -1);
    tick();
    apply_par(v);
    fg_opto = 1'b0;
    start = 1'b1;
    first = -1; n_det = 0; n_trg = 0; n_done = 0;
    for (int c = 1; c <= 80; c++) begin
      tick();
      if (c == 2) start = 1'b0;
      if (c == 3 || c == 12) fg_opto = 1'b1;
      if (c == 9) fg_opto = 1'b0;
      if (first >= 0 && c == first + 1) begin
        ch_en = 4'b0000;
        par.trigger_len = 9;
        phase_shift[0] = 5;
      end
      #1;
      if (detonate && first < 0) first = c;
      n_det  += int'(detonate);
      n_trg  += int'(output_trigger[0]);
      n_done += int'(done);
    end
    check("fgdrop_fire_cycle", first, 24);
    check("fgdrop_det_width", n_det, 3);
    check("fgdrop_trg_width_latched", n_trg, 3);
    check("fgdrop_done_count", n_done, 1);
    check("fgdrop_idle", int'(busy), 0);
    fg_opto = 1'b0;

    // Asynchronous reset in the middle of a fire.
    v = mk(2, 0, 20, 20, 1, 2, 4'b1111, 4'b1111, 0, 0, 0, 0, -1, -1);
    tick();
    apply_par(v);
    fg_opto = 1'b1;
    start = 1'b1;
    first = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 2) start = 1'b0;
      #1;
      if (detonate && first < 0) first = c;
      if (first >= 0 && c == first + 3) break;
    end
    check("rst_mid_fire_active", int'({detonate, output_trigger}), 5'b11111);
    reset = 1'b1;
    #0.5;
    check("rst_mid_fire_outputs", int'({detonate, output_trigger, busy, done}), 0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("rst_mid_fire_idle", int'(busy), 0);

`ifdef CALIB_ABORT_EN
    tick();
    start = 1'b1;
    first = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 2) start = 1'b0;
      #1;
      if (detonate && first < 0) first = c;
      if (first >= 0 && c == first + 3) break;
    end
    check("abort_fire_active", int'(detonate), 1);
    abort = 1'b1;
    #0.5;
    check("abort_outputs_gated", int'({detonate, output_trigger}), 0);
    tick();
    abort = 1'b0;
    check("abort_idle", int'(busy), 0);
    n_done = 0;
    n_det = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      n_done += int'(done);
      n_det  += int'(detonate);
    end
    check("abort_no_done", n_done, 0);
    check("abort_no_more_fire", n_det, 0);
    check("abort_err_unchanged", int'(timeout_err), 0);
`endif

    fg_opto = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
